// File: rtl/lib_ring_ptr_v1.sv
// lib_ring_ptr_v1 -- pointer/occupancy manager for a runtime-length ring buffer.
// It only produces slot indices; the storage array lives elsewhere.
//
// Parameters:
//   PTR_W     pointer width
//   DEPTH_MAX maximum ring length (<= 2**PTR_W); also the fallback length
//   OVWR_MODE 0: drop writes while full, 1: overwrite the oldest entry
// Ports:
//   clk, reset_n      clock, async active-low reset
//   reset_s, len_i    sync clear + ring length load
//   wr_en, rd_en      advance write / read pointer
//   look_en, look_off_i  lookback request, distance from newest entry
//   wr_ptr_o, rd_ptr_o   next write slot, oldest valid slot
//   look_ptr_o, look_vld_o  registered lookback slot and its update pulse
//   cnt_o, full_o, empty_o  occupancy and its decodes
//   ovrflw_flg, undflw_flg, look_err_flg  single-cycle error pulses
module lib_ring_ptr_v1 #(
  parameter int PTR_W     = 4,
  parameter int DEPTH_MAX = 16,
  parameter bit OVWR_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reset_s,
  input  logic [PTR_W:0]   len_i,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             look_en,
  input  logic [PTR_W-1:0] look_off_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W-1:0] look_ptr_o,
  output logic             look_vld_o,
  output logic [PTR_W:0]   cnt_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovrflw_flg,
  output logic             undflw_flg,
  output logic             look_err_flg
);

  localparam int CW = PTR_W + 1;
  localparam logic [CW-1:0] LEN_MAX = CW'(DEPTH_MAX);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] look_ptr_q, look_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    len_q, len_d;
  logic             look_vld_q, look_vld_d;
  logic             ovrflw_q, ovrflw_d;
  logic             undflw_q, undflw_d;
  logic             look_err_q, look_err_d;

  logic full, empty;
  logic wr_acc, rd_acc, rd_adv;

  // Wrap compare done at CW bits so len_q == 2**PTR_W works.
  function automatic logic [PTR_W-1:0] adv(input logic [PTR_W-1:0] p,
                                           input logic [CW-1:0]    len);
    logic [CW-1:0] inc;
    inc = {1'b0, p} + CW'(1);
    if (inc == len) inc = '0;
    return inc[PTR_W-1:0];
  endfunction

  // Remainder of a by runtime length m (restoring division); the offset
  // may exceed the ring length, so it has to be reduced first.
  function automatic logic [CW-1:0] mod_len(input logic [PTR_W-1:0] a,
                                            input logic [CW-1:0]    m);
    logic [CW:0] r;
    r = '0;
    for (int i = PTR_W - 1; i >= 0; i--) begin
      r = {r[CW-1:0], a[i]};
      if (r >= {1'b0, m}) r = r - {1'b0, m};
    end
    return r[CW-1:0];
  endfunction

  // (wr - 1 - off) mod len, kept non-negative by adding len before subtracting.
  function automatic logic [PTR_W-1:0] look_slot(input logic [PTR_W-1:0] wr,
                                                 input logic [PTR_W-1:0] off,
                                                 input logic [CW-1:0]    len);
    logic [CW:0] b;
    b = {2'b00, wr} + {1'b0, len} - (CW+1)'(1) - {1'b0, mod_len(off, len)};
    if (b >= {1'b0, len}) b = b - {1'b0, len};
    return b[PTR_W-1:0];
  endfunction

  assign full  = (cnt_q == len_q);
  assign empty = (cnt_q == '0);

  // Full with a concurrent read: both go through, so the write is never
  // dropped there. Overwrite pushes the read pointer along with the write.
  assign wr_acc = wr_en && (!full || rd_en || OVWR_MODE);
  assign rd_acc = rd_en && !empty;
  assign rd_adv = rd_acc || (wr_en && full && !rd_en && OVWR_MODE);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    look_ptr_d = look_ptr_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    look_vld_d = 1'b0;
    ovrflw_d   = 1'b0;
    undflw_d   = 1'b0;
    look_err_d = 1'b0;

    if (reset_s) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      look_ptr_d = '0;
      cnt_d      = '0;
      len_d      = (len_i == '0 || len_i > LEN_MAX) ? LEN_MAX : len_i;
    end else begin
      if (wr_acc) wr_ptr_d = adv(wr_ptr_q, len_q);
      if (rd_adv) rd_ptr_d = adv(rd_ptr_q, len_q);

      if (wr_acc && !rd_acc && !full)   cnt_d = cnt_q + CW'(1);
      else if (rd_acc && !wr_acc)       cnt_d = cnt_q - CW'(1);

      ovrflw_d = wr_en && full && !rd_en;
      undflw_d = rd_en && empty;

      if (look_en) begin
        look_ptr_d = look_slot(wr_ptr_q, look_off_i, len_q);
        look_vld_d = 1'b1;
        look_err_d = ({1'b0, look_off_i} >= cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      look_ptr_q <= '0;
      cnt_q      <= '0;
      len_q      <= LEN_MAX;
      look_vld_q <= 1'b0;
      ovrflw_q   <= 1'b0;
      undflw_q   <= 1'b0;
      look_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      look_ptr_q <= look_ptr_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      look_vld_q <= look_vld_d;
      ovrflw_q   <= ovrflw_d;
      undflw_q   <= undflw_d;
      look_err_q <= look_err_d;
    end
  end

  assign wr_ptr_o     = wr_ptr_q;
  assign rd_ptr_o     = rd_ptr_q;
  assign look_ptr_o   = look_ptr_q;
  assign look_vld_o   = look_vld_q;
  assign cnt_o        = cnt_q;
  assign full_o       = full;
  assign empty_o      = empty;
  assign ovrflw_flg   = ovrflw_q;
  assign undflw_flg   = undflw_q;
  assign look_err_flg = look_err_q;

endmodule

// File: tb/tb_lib_ring_ptr_v1.sv
// Directed bench for lib_ring_ptr_v1: one instance per overwrite mode, driven
// from shared inputs; expected values are queued per step and checked after
// the clock edge.
module tb_lib_ring_ptr_v1;

  localparam int PTR_W = 4;

  logic       clk = 1'b0;
  logic       reset_n, reset_s, wr_en, rd_en, look_en;
  logic [4:0] len_i;
  logic [3:0] look_off_i;

  logic [3:0] wr0, rd0, lp0, wr1, rd1, lp1;
  logic [4:0] cnt0, cnt1;
  logic lv0, full0, empty0, ovf0, udf0, le0;
  logic lv1, full1, empty1, ovf1, udf1, le1;

  always #5 clk = ~clk;

  lib_ring_ptr_v1 #(.PTR_W(PTR_W), .DEPTH_MAX(16), .OVWR_MODE(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .reset_s(reset_s), .len_i(len_i),
    .wr_en(wr_en), .rd_en(rd_en), .look_en(look_en), .look_off_i(look_off_i),
    .wr_ptr_o(wr0), .rd_ptr_o(rd0), .look_ptr_o(lp0), .look_vld_o(lv0),
    .cnt_o(cnt0), .full_o(full0), .empty_o(empty0), .ovrflw_flg(ovf0),
    .undflw_flg(udf0), .look_err_flg(le0));

  lib_ring_ptr_v1 #(.PTR_W(PTR_W), .DEPTH_MAX(16), .OVWR_MODE(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .reset_s(reset_s), .len_i(len_i),
    .wr_en(wr_en), .rd_en(rd_en), .look_en(look_en), .look_off_i(look_off_i),
    .wr_ptr_o(wr1), .rd_ptr_o(rd1), .look_ptr_o(lp1), .look_vld_o(lv1),
    .cnt_o(cnt1), .full_o(full1), .empty_o(empty1), .ovrflw_flg(ovf1),
    .undflw_flg(udf1), .look_err_flg(le1));

  localparam int S_WR = 0, S_RD = 1, S_CNT = 2, S_FULL = 3, S_EMPTY = 4,
                 S_OVF = 5, S_UDF = 6, S_LP = 7, S_LV = 8, S_LE = 9, D1 = 10;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_WR:         return 32'(wr0);
      S_RD:         return 32'(rd0);
      S_CNT:        return 32'(cnt0);
      S_FULL:       return 32'(full0);
      S_EMPTY:      return 32'(empty0);
      S_OVF:        return 32'(ovf0);
      S_UDF:        return 32'(udf0);
      S_LP:         return 32'(lp0);
      S_LV:         return 32'(lv0);
      S_LE:         return 32'(le0);
      D1 + S_WR:    return 32'(wr1);
      D1 + S_RD:    return 32'(rd1);
      D1 + S_CNT:   return 32'(cnt1);
      D1 + S_FULL:  return 32'(full1);
      D1 + S_EMPTY: return 32'(empty1);
      D1 + S_OVF:   return 32'(ovf1);
      D1 + S_UDF:   return 32'(udf1);
      D1 + S_LP:    return 32'(lp1);
      D1 + S_LV:    return 32'(lv1);
      D1 + S_LE:    return 32'(le1);
      default:      return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    sb_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic push2(input string tag, input int sel, input logic [31:0] v);
    push({tag, "_m0"}, sel, v);
    push({tag, "_m1"}, sel + D1, v);
  endtask

  task automatic drain();
    sb_t         e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      n_cmp++;
      assert (o === e.exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic drive(input logic rs, input logic [4:0] len, input logic w,
                       input logic r, input logic lk, input logic [3:0] off);
    reset_s = rs; len_i = len; wr_en = w; rd_en = r; look_en = lk; look_off_i = off;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    push2("rst_wr", S_WR, 0);    push2("rst_rd", S_RD, 0);
    push2("rst_cnt", S_CNT, 0);  push2("rst_empty", S_EMPTY, 1);
    push2("rst_lp", S_LP, 0);    push2("rst_lv", S_LV, 0);
    push2("rst_ovf", S_OVF, 0);  push2("rst_udf", S_UDF, 0);
    drain();
    #10 reset_n = 1'b1;

    // length 5, wrap on the fifth write
    drive(1, 5, 0, 0, 0, 0);
    push2("ld5_cnt", S_CNT, 0);
    step();
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      push2("wrap_wr", S_WR, i % 5);
      push2("wrap_cnt", S_CNT, i);
      step();
    end
    push2("wrap_full", S_FULL, 1);
    drain();

    // write while full
    drive(0, 0, 1, 0, 0, 0);
    push("ovf_wr_m0", S_WR, 0);        push("ovf_rd_m0", S_RD, 0);
    push("ovf_cnt_m0", S_CNT, 5);      push("ovf_flg_m0", S_OVF, 1);
    push("ovf_wr_m1", D1 + S_WR, 1);   push("ovf_rd_m1", D1 + S_RD, 1);
    push("ovf_cnt_m1", D1 + S_CNT, 5); push("ovf_flg_m1", D1 + S_OVF, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    push2("ovf_pulse_end", S_OVF, 0);
    step();

    // write+read while full: both accepted, no overflow
    drive(0, 0, 1, 1, 0, 0);
    push("fwr_wr_m0", S_WR, 1);        push("fwr_rd_m0", S_RD, 1);
    push("fwr_wr_m1", D1 + S_WR, 2);   push("fwr_rd_m1", D1 + S_RD, 2);
    push2("fwr_cnt", S_CNT, 5);        push2("fwr_ovf", S_OVF, 0);
    step();

    // sync clear mid-stream; the write in the same cycle is ignored
    drive(1, 5, 1, 0, 0, 0);
    push2("rs_wr", S_WR, 0); push2("rs_rd", S_RD, 0);
    push2("rs_cnt", S_CNT, 0); push2("rs_empty", S_EMPTY, 1);
    step();

    // empty read, then write+read on empty
    drive(0, 0, 0, 1, 0, 0);
    push2("udf_flg", S_UDF, 1); push2("udf_rd", S_RD, 0); push2("udf_cnt", S_CNT, 0);
    step();
    drive(0, 0, 1, 1, 0, 0);
    push2("ewr_cnt", S_CNT, 1); push2("ewr_udf", S_UDF, 1);
    push2("ewr_wr", S_WR, 1);   push2("ewr_rd", S_RD, 0);
    step();
    drive(0, 0, 0, 1, 0, 0);
    push2("rd1_cnt", S_CNT, 0); push2("rd1_rd", S_RD, 1); push2("rd1_udf", S_UDF, 0);
    step();

    // lookback at length 16
    drive(1, 16, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      step();
    end
    push2("lb_cnt", S_CNT, 3); push2("lb_wr", S_WR, 3);
    drain();
    drive(0, 0, 0, 0, 1, 0);
    push2("lb0_lp", S_LP, 2);  push2("lb0_lv", S_LV, 1); push2("lb0_le", S_LE, 0);
    step();
    drive(0, 0, 0, 0, 1, 2);
    push2("lb2_lp", S_LP, 0);  push2("lb2_lv", S_LV, 1); push2("lb2_le", S_LE, 0);
    step();
    drive(0, 0, 0, 0, 1, 3);
    push2("lb3_lp", S_LP, 15); push2("lb3_lv", S_LV, 1); push2("lb3_le", S_LE, 1);
    push2("lb3_cnt", S_CNT, 3); push2("lb3_wr", S_WR, 3);
    step();
    drive(0, 0, 0, 0, 0, 0);
    push2("lb_lv_end", S_LV, 0); push2("lb_le_end", S_LE, 0);
    step();

    // length clamp: len_i=0 loads 16
    drive(1, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      step();
    end
    push2("clamp15_full", S_FULL, 0); push2("clamp15_cnt", S_CNT, 15);
    drain();
    drive(0, 0, 1, 0, 0, 0);
    push2("clamp16_full", S_FULL, 1); push2("clamp16_cnt", S_CNT, 16);
    push2("clamp16_wr", S_WR, 0);
    step();
    drive(0, 0, 0, 0, 1, 5);
    push2("lb5_lp", S_LP, 10); push2("lb5_lv", S_LV, 1);
    step();

    // async reset mid-stream, checked before the next edge
    drive(0, 0, 1, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    push2("arst_wr", S_WR, 0);   push2("arst_rd", S_RD, 0);
    push2("arst_cnt", S_CNT, 0); push2("arst_lp", S_LP, 0);
    push2("arst_lv", S_LV, 0);   push2("arst_full", S_FULL, 0);
    drain();
    drive(0, 0, 0, 0, 0, 0);
    #10 reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lib_ring_ptr_v1.md
LIB_RING_PTR_V1 -- requirements
Module: lib_ring_ptr_v1

Interface
Parameters:
REQ-001 The block SHALL have parameter PTR_W, default 4, which sets the pointer width.
REQ-002 The block SHALL have parameter DEPTH_MAX, default 16, which sets the maximum ring length and SHALL be no greater than 2^PTR_W.
REQ-003 The block SHALL have parameter OVWR_MODE, default 0: 0 means drop writes when full; 1 means overwrite the oldest entry.

Ports:
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 reset_s  in  1  synchronous clear and length load; highest priority after reset_n.
REQ-007 len_i  in  PTR_W+1  runtime ring length, sampled only while reset_s=1.
REQ-008 wr_en  in  1  write request: advance the write pointer.
REQ-009 rd_en  in  1  read request: advance the read pointer.
REQ-010 look_en  in  1  lookback request.
REQ-011 look_off_i  in  PTR_W  lookback distance from the newest entry (0 = newest).
REQ-012 wr_ptr_o  out  PTR_W  next write slot.
REQ-013 rd_ptr_o  out  PTR_W  oldest valid slot.
REQ-014 look_ptr_o  out  PTR_W  registered lookback slot.
REQ-015 look_vld_o  out  1  one-cycle pulse: look_ptr_o is updated.
REQ-016 cnt_o  out  PTR_W+1  current occupancy, 0..len_q.
REQ-017 full_o / empty_o  out  1 each  combinational decodes: full_o = (cnt_o==len_q); empty_o = (cnt_o==0).
REQ-018 ovrflw_flg  out  1  registered pulse: a write was attempted while full.
REQ-019 undflw_flg  out  1  registered pulse: a read was attempted while empty.
REQ-020 look_err_flg  out  1  registered pulse: lookback distance was not less than occupancy.

Function
REQ-021 The block SHALL hold len_q internally; on reset_s it SHALL load len_i, except len_i==0 or len_i>DEPTH_MAX SHALL load DEPTH_MAX.
REQ-022 Each pointer advance SHALL wrap: next = (ptr==len_q-1) ? 0 : ptr+1, computed at PTR_W+1 bits with no truncation before the compare.
REQ-023 Write acceptance: wr_en with !full_o SHALL advance wr_ptr_o.
REQ-024 Write while full, OVWR_MODE=0: wr_en with full_o SHALL be dropped, with no pointer or count change, and ovrflw_flg=1 next cycle.
REQ-025 Write while full, OVWR_MODE=1: wr_en with full_o SHALL advance both wr_ptr_o and rd_ptr_o, leave cnt_o=len_q, and set ovrflw_flg=1 next cycle.
REQ-026 Read acceptance: rd_en with !empty_o SHALL advance rd_ptr_o; rd_en with empty_o SHALL be rejected, with undflw_flg=1 next cycle.
REQ-027 Count update: cnt_o SHALL increment on an accepted write only, decrement on an accepted read only, and be unchanged otherwise.
REQ-028 Simultaneous wr_en and rd_en when empty: the write SHALL be accepted and the read rejected, giving cnt_o=1 and undflw_flg=1.
REQ-029 Simultaneous wr_en and rd_en when full: both SHALL be accepted in either mode, with cnt_o unchanged and ovrflw_flg=0.
REQ-030 Simultaneous wr_en and rd_en otherwise: both SHALL be accepted with cnt_o unchanged.
REQ-031 Lookback: on look_en, look_ptr_o SHALL be registered as (wr_ptr_o - 1 - look_off_i) mod len_q, using pre-edge state, and look_vld_o SHALL pulse one cycle later.
REQ-032 Lookback error: if look_off_i >= cnt_o at request time, look_ptr_o SHALL still update and look_err_flg SHALL pulse together with look_vld_o.
REQ-033 Lookback SHALL NOT alter pointers or count; concurrent wr_en and rd_en SHALL proceed independently.
REQ-034 All flags SHALL be single-cycle pulses, deasserting the following cycle unless the condition repeats.

Reset
REQ-035 On reset_n=0, asynchronously: wr_ptr_o=0, rd_ptr_o=0, look_ptr_o=0, cnt_o=0, len_q=DEPTH_MAX, and all flags and look_vld_o=0.
REQ-036 On reset_s=1 at an edge: pointers, count, flags and look_vld_o SHALL clear to 0, len_q SHALL load per REQ-021, and wr_en, rd_en and look_en that cycle SHALL be ignored.
REQ-037 A reset arriving mid-operation SHALL discard all occupancy, with no partial state retained.

Verification
REQ-038 Wrap test: len_i=5 loaded via reset_s; 5 writes -> wr_ptr_o 1,2,3,4,0; cnt_o=5; full_o=1.
REQ-039 Full write, OVWR_MODE=0: 6th write -> ovrflw_flg pulse; wr_ptr_o=0; cnt_o=5. Full write, OVWR_MODE=1: 6th write -> wr_ptr_o=1, rd_ptr_o=1, cnt_o=5.
REQ-040 Empty read and write: rd_en alone -> undflw_flg pulse, rd_ptr_o=0. Then wr_en+rd_en together -> cnt_o=1, undflw_flg=1.
REQ-041 Lookback, len=16: after 3 writes, look_off_i=0 -> look_ptr_o=2; look_off_i=2 -> look_ptr_o=0; look_off_i=3 -> look_ptr_o=15 with look_err_flg=1; look_vld_o one cycle after each request.
REQ-042 Length clamp: reset_s with len_i=0 -> len_q=16, so 16 writes are needed for full_o. Reset_n asserted mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
